// File: rtl/useq_pkg.sv
// Shared opcodes and control-word field offsets for the micro-sequencer.
package useq_pkg;

  localparam logic [2:0] NS_DECODE  = 3'd0;
  localparam logic [2:0] NS_RESTART = 3'd1;
  localparam logic [2:0] NS_JUMP    = 3'd2;
  localparam logic [2:0] NS_INC     = 3'd3;
  localparam logic [2:0] NS_CJUMP   = 3'd4;
  localparam logic [2:0] NS_WAIT    = 3'd5;
  localparam logic [2:0] NS_CALL    = 3'd6;
  localparam logic [2:0] NS_RET     = 3'd7;

  function automatic int ns_lsb(input int cw);
    return cw - 3;
  endfunction

  function automatic int inv_pos(input int cw);
    return cw - 4;
  endfunction

  function automatic int sel_w(input int ncond);
    return $clog2(ncond);
  endfunction

  function automatic int sel_lsb(input int cw, input int ncond);
    return cw - 4 - $clog2(ncond);
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Return-address stack; push/pop are never asserted together.
module useq_stack #(
  parameter int SW = 7,
  parameter int SD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [SW-1:0]            din,
  output logic [SW-1:0]            top,
  output logic [$clog2(SD+1)-1:0]  depth,
  output logic                     full,
  output logic                     empty
);

  localparam int DW = $clog2(SD + 1);
  localparam int AW = (SD > 1) ? $clog2(SD) : 1;
  localparam int NE = 2 ** AW;

  logic [SW-1:0] mem_q [NE];
  logic [DW-1:0] depth_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = AW'(depth_q);
  assign rd_idx = AW'(depth_q - 1'b1);
  assign full   = (depth_q == DW'(SD));
  assign empty  = (depth_q == '0);
  assign top    = empty ? '0 : mem_q[rd_idx];
  assign depth  = depth_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      for (int i = 0; i < NE; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_idx] <= din;
      depth_q       <= depth_q + 1'b1;
    end else if (pop) begin
      depth_q <= depth_q - 1'b1;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address select, control-word register
// and return stack. Microstore and instruction encoder live outside.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter int SW         = 7,
  parameter int CW         = 33,
  parameter int NCOND      = 4,
  parameter int SD         = 4,
  parameter int FETCH_ADDR = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SW-1:0]            decode_addr,
  input  logic [NCOND-1:0]         cond,
  output logic [SW-1:0]            uaddr,
  input  logic [CW-1:0]            uword,
  output logic [CW-1:0]            cw,
  output logic [SW-1:0]            state,
  output logic [$clog2(SD+1)-1:0]  depth,
  output logic                     err
);

  localparam int SELW = sel_w(NCOND);
  localparam int NSL  = ns_lsb(CW);
  localparam int INVP = inv_pos(CW);
  localparam int SELL = sel_lsb(CW, NCOND);
  localparam logic [SW-1:0] FETCH = SW'(FETCH_ADDR);

  logic [CW-1:0]   cw_q;
  logic [SW-1:0]   state_q;
  logic [SW-1:0]   state_d;
  logic            started_q;
  logic            err_q;

  logic [2:0]      ns;
  logic            inv;
  logic [SELW-1:0] sel;
  logic [SW-1:0]   tgt;
  logic [SW-1:0]   inc;
  logic            sts;

  logic            is_call;
  logic            is_ret;
  logic            push;
  logic            pop;
  logic [SW-1:0]   top;
  logic            full;
  logic            empty;

  assign ns  = cw_q[NSL +: 3];
  assign inv = cw_q[INVP];
  assign sel = cw_q[SELL +: SELW];
  assign tgt = cw_q[SW-1:0];
  assign inc = state_q + 1'b1;
  assign sts = cond[sel] ^ inv;

  // Nothing acts on cw until the first post-reset fetch has landed.
  assign is_call = started_q && (ns == NS_CALL);
  assign is_ret  = started_q && (ns == NS_RET);
  assign push    = is_call && !full;
  assign pop     = is_ret && !empty;

  useq_stack #(
    .SW (SW),
    .SD (SD)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (top),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d = '0;
    if (started_q) begin
      unique case (ns)
        NS_DECODE:  state_d = decode_addr;
        NS_RESTART: state_d = FETCH;
        NS_JUMP:    state_d = tgt;
        NS_INC:     state_d = inc;
        NS_CJUMP:   state_d = sts ? tgt : inc;
        NS_WAIT:    state_d = sts ? inc : state_q;
        NS_CALL:    state_d = tgt;
        NS_RET:     state_d = empty ? FETCH : top;
        default:    state_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw_q      <= '0;
      state_q   <= '0;
      started_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cw_q      <= uword;
      state_q   <= state_d;
      started_q <= 1'b1;
      if ((is_call && full) || (is_ret && empty)) err_q <= 1'b1;
    end
  end

  assign uaddr = state_d;
  assign cw    = cw_q;
  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer with a queue-based scoreboard.
module tb_micro_sequencer;

  localparam int SW    = 7;
  localparam int CW    = 33;
  localparam int NCOND = 4;
  localparam int SD    = 2;
  localparam int FA    = 1;

  localparam int ID_UADDR = 0;
  localparam int ID_STATE = 1;
  localparam int ID_DEPTH = 2;
  localparam int ID_ERR   = 3;
  localparam int ID_CW    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [SW-1:0]    decode_addr;
  logic [NCOND-1:0] cond;
  logic [SW-1:0]    uaddr;
  logic [CW-1:0]    uword;
  logic [CW-1:0]    cw;
  logic [SW-1:0]    state;
  logic [1:0]       depth;
  logic             err;

  logic [CW-1:0]    rom [128];

  assign uword = rom[uaddr];

  always #5 clk = ~clk;

  micro_sequencer #(
    .SW         (SW),
    .CW         (CW),
    .NCOND      (NCOND),
    .SD         (SD),
    .FETCH_ADDR (FA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .decode_addr (decode_addr),
    .cond        (cond),
    .uaddr       (uaddr),
    .uword       (uword),
    .cw          (cw),
    .state       (state),
    .depth       (depth),
    .err         (err)
  );

  typedef struct {
    string         nm;
    int            id;
    logic [CW-1:0] v;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;
  event chk;

  function automatic logic [CW-1:0] mk(input int ns, input bit inv,
                                       input int sel, input int tgt,
                                       input int moore);
    logic [CW-1:0] w;
    w        = '0;
    w[32:30] = 3'(ns);
    w[29]    = inv;
    w[28:27] = 2'(sel);
    w[26:7]  = 20'(moore);
    w[6:0]   = 7'(tgt);
    return w;
  endfunction

  function automatic logic [CW-1:0] probe(input int id);
    logic [CW-1:0] r;
    r = '0;
    case (id)
      ID_UADDR: r = CW'(uaddr);
      ID_STATE: r = CW'(state);
      ID_DEPTH: r = CW'(depth);
      ID_ERR:   r = CW'(err);
      default:  r = cw;
    endcase
    return r;
  endfunction

  task automatic want(input string nm, input int id,
                      input logic [CW-1:0] v);
    exp_t e;
    e.nm = nm;
    e.id = id;
    e.v  = v;
    q.push_back(e);
  endtask

  task automatic fire();
    ->chk;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains the queue each time the driver publishes a sample point.
  initial begin
    exp_t          e;
    logic [CW-1:0] a;
    forever begin
      @(chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = probe(e.id);
        nvec++;
        if (a !== e.v) begin
          nbad++;
          $display("FAIL %s: got %0h expected %0h", e.nm, a, e.v);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0]   = mk(1, 0, 0, 0,   16'h1000);
    rom[1]   = mk(5, 0, 0, 0,   16'h1001);
    rom[2]   = mk(4, 1, 1, 5,   16'h1002);
    rom[5]   = mk(6, 0, 0, 40,  16'h1005);
    rom[40]  = mk(7, 0, 0, 0,   16'h1040);
    rom[6]   = mk(6, 0, 0, 50,  16'h1006);
    rom[50]  = mk(6, 0, 0, 60,  16'h1050);
    rom[60]  = mk(6, 0, 0, 70,  16'h1060);
    rom[70]  = mk(5, 0, 1, 0,   16'h1070);
    rom[127] = mk(3, 0, 0, 0,   16'h1127);
    rom[80]  = mk(7, 0, 0, 0,   16'h1080);

    reset       = 1'b1;
    cond        = '0;
    decode_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    want("rst_state", ID_STATE, 0);
    want("rst_cw",    ID_CW,    0);
    want("rst_depth", ID_DEPTH, 0);
    want("rst_err",   ID_ERR,   0);
    want("rst_uaddr", ID_UADDR, 0);
    fire();

    reset = 1'b0;
    want("pre_edge_uaddr", ID_UADDR, 0);
    fire();

    step();
    want("edge1_state", ID_STATE, 0);
    want("edge1_cw",    ID_CW,    rom[0]);
    want("edge1_uaddr", ID_UADDR, 1);
    fire();

    step();
    want("edge2_state", ID_STATE, 1);
    want("wait_uaddr",  ID_UADDR, 1);
    fire();

    for (int i = 0; i < 3; i++) begin
      step();
      want("wait_state", ID_STATE, 1);
      want("wait_cw",    ID_CW,    rom[1]);
      fire();
    end

    cond = 4'b0001;
    want("wait_go_uaddr", ID_UADDR, 2);
    fire();
    step();
    want("wait_exit_state", ID_STATE, 2);
    want("cjump_inv_uaddr", ID_UADDR, 5);
    fire();

    step();
    want("call_state", ID_STATE, 5);
    want("call_depth", ID_DEPTH, 0);
    want("call_uaddr", ID_UADDR, 40);
    fire();

    step();
    want("sub_state", ID_STATE, 40);
    want("sub_depth", ID_DEPTH, 1);
    want("ret_uaddr", ID_UADDR, 6);
    fire();

    step();
    want("ret_state", ID_STATE, 6);
    want("ret_depth", ID_DEPTH, 0);
    want("ret_err",   ID_ERR,   0);
    fire();

    step();
    want("nest1_state", ID_STATE, 50);
    want("nest1_depth", ID_DEPTH, 1);
    fire();

    step();
    want("nest2_state", ID_STATE, 60);
    want("nest2_depth", ID_DEPTH, 2);
    want("nest2_err",   ID_ERR,   0);
    fire();

    step();
    want("ovf_state", ID_STATE, 70);
    want("ovf_depth", ID_DEPTH, 2);
    want("ovf_err",   ID_ERR,   1);
    want("wait2_uaddr", ID_UADDR, 70);
    fire();

    repeat (2) begin
      step();
      want("wait2_state", ID_STATE, 70);
      want("wait2_cw",    ID_CW,    rom[70]);
      want("err_sticky",  ID_ERR,   1);
      fire();
    end

    reset = 1'b1;
    #1;
    want("midrst_state", ID_STATE, 0);
    want("midrst_depth", ID_DEPTH, 0);
    want("midrst_err",   ID_ERR,   0);
    want("midrst_cw",    ID_CW,    0);
    want("midrst_uaddr", ID_UADDR, 0);
    fire();

    rom[0]      = mk(0, 0, 0, 0, 16'h2000);
    decode_addr = 7'd127;
    @(posedge clk);
    #1;
    reset = 1'b0;

    step();
    want("b_edge1_state", ID_STATE, 0);
    want("decode_uaddr",  ID_UADDR, 127);
    fire();

    step();
    want("top_state",  ID_STATE, 127);
    want("wrap_uaddr", ID_UADDR, 0);
    fire();

    step();
    want("wrap_state", ID_STATE, 0);
    fire();
    decode_addr = 7'd80;
    want("decode2_uaddr", ID_UADDR, 80);
    fire();

    step();
    want("uflow_pre_state", ID_STATE, 80);
    want("uflow_pre_err",   ID_ERR,   0);
    want("uflow_uaddr",     ID_UADDR, FA);
    fire();

    step();
    want("uflow_state", ID_STATE, FA);
    want("uflow_err",   ID_ERR,   1);
    want("uflow_depth", ID_DEPTH, 0);
    fire();

    #2;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 The block SHALL have parameter SW, default 7, meaning microstate address width.
REQ-002 The block SHALL have parameter CW, default 33, meaning control-word width (must be >= SW+8).
REQ-003 The block SHALL have parameter NCOND, default 4, meaning condition input count (power of two, >= 2).
REQ-004 The block SHALL have parameter SD, default 4, meaning return-stack depth (>= 1).
REQ-005 The block SHALL have parameter FETCH_ADDR, default 1, meaning restart/fetch microstate.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning single clock (rising edge).
REQ-007 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-008 The block SHALL have port decode_addr, input, SW bits, meaning entry state from the instruction encoder.
REQ-009 The block SHALL have port cond, input, NCOND bits, meaning status inputs (bit 0 = MOC, bit 1 = Cond).
REQ-010 The block SHALL have port uaddr, output, SW bits, meaning combinational microstore address.
REQ-011 The block SHALL have port uword, input, CW bits, meaning microstore data for uaddr (combinational ROM).
REQ-012 The block SHALL have port cw, output, CW bits, meaning registered control word.
REQ-013 The block SHALL have port state, output, SW bits, meaning registered current microstate.
REQ-014 The block SHALL have port depth, output, clog2(SD+1) bits, meaning return-stack occupancy.
REQ-015 The block SHALL have port err, output, 1 bit, meaning sticky stack over/underflow flag.

Function
REQ-016 The block SHALL decode cw fields as follows: NS = cw[CW-1:CW-3], INV = cw[CW-4], SEL = next clog2(NCOND) bits, TGT = cw[SW-1:0], and the remaining bits as Moore outputs (passed through untouched).
REQ-017 The block SHALL compute sts = cond[SEL] XOR INV combinationally.
REQ-018 The block SHALL compute uaddr per NS as follows: 0 DECODE -> decode_addr; 1 RESTART -> FETCH_ADDR; 2 JUMP -> TGT; 3 INC -> state+1; 4 CJUMP -> sts ? TGT : state+1; 5 WAIT -> sts ? state+1 : state; 6 CALL -> TGT; 7 RET -> stack top, or FETCH_ADDR if the stack is empty.
REQ-019 On each rising clk, the block SHALL load cw <= uword and state <= uaddr, giving a latency of one cycle from address to control word.
REQ-020 The block SHALL compute state+1 modulo 2^SW, so that all-ones wraps to 0.
REQ-021 On CALL with depth < SD, the block SHALL push state+1 (mod 2^SW) and increment depth.
REQ-022 On CALL with depth == SD, the block SHALL discard the push, leave depth unchanged, still jump to TGT, and set err.
REQ-023 On RET with depth > 0, the block SHALL pop the stack and decrement depth.
REQ-024 On RET with depth == 0, the block SHALL go to FETCH_ADDR, leave depth at 0, and set err.
REQ-025 The block SHALL perform at most one stack operation per cycle, with no simultaneous push/pop case.
REQ-026 Once err is set, the block SHALL hold it until reset.
REQ-027 In WAIT with sts false, the block SHALL hold state and cw for an unbounded number of cycles.

Reset
REQ-028 While reset is high, the block SHALL hold cw = 0, state = 0, depth = 0, err = 0 and an internal started flag = 0, and SHALL force uaddr = 0.
REQ-029 While started = 0, the block SHALL force uaddr = 0 regardless of cw.
REQ-030 On the first rising clk after reset falls, the block SHALL load cw = uword(0), state = 0 and started = 1.
REQ-031 If reset is asserted mid-WAIT or mid-subroutine, the block SHALL clear all state immediately, including stack contents.

Structure
REQ-032 The NS opcode constants (DECODE..RET) and the field-offset functions of CW/SW/NCOND SHALL be placed in the shared package useq_pkg.
REQ-033 The return stack SHALL be implemented as one sub-module, useq_stack (parameters SW, SD), with ports push, pop, din, top, depth, full and empty.
REQ-034 The microstore and instruction encoder SHALL remain external to this block.

Verification
REQ-035 Release reset with ROM[0] NS = RESTART: the bench SHALL check uaddr = 0 before the first edge, state = 0 after the first edge, and state = 1 after the second edge.
REQ-036 With ROM[1] = WAIT, SEL = 0, INV = 0 and cond[0] = 0 for 3 cycles then 1: the bench SHALL check that state stays 1 for 3 edges and then becomes 2.
REQ-037 With ROM[5] = CALL, TGT = 40 and ROM[40] = RET: the bench SHALL check the sequence 5 -> 40 -> 6, with depth going 0 -> 1 -> 0 and err = 0.
REQ-038 With SD = 2 and three nested CALLs: the bench SHALL check that depth saturates at 2, err = 1, and the third CALL still reaches its TGT.
REQ-039 With RET on an empty stack: the bench SHALL check next state = FETCH_ADDR = 1 and err = 1.
REQ-040 With SW = 7, state = 127 and NS = INC: the bench SHALL check next state = 0; the bench SHALL also check that asserting reset during WAIT clears depth and err within the same cycle.
